// File: rtl/alu_muldiv_seq_if.sv
//------------------------------------------------------------------------------
// Module : alu_muldiv_seq_if
// Brief  : Host request/result and shared-ALU bus for the mul/div sequencer.
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface alu_muldiv_seq_if;
    logic       start;
    logic       op_div;
    logic [9:0] opnd_a;
    logic [9:0] opnd_b;
    logic [9:0] host_a;
    logic [9:0] host_b;
    logic [1:0] host_op;
    logic [9:0] alu_a;
    logic [9:0] alu_b;
    logic [1:0] alu_op;
    logic [9:0] alu_result;
    logic       busy;
    logic       done;
    logic       err;
    logic [9:0] result_lo;
    logic [9:0] result_hi;

    modport master (
        output start, op_div, opnd_a, opnd_b, host_a, host_b, host_op, alu_result,
        input  alu_a, alu_b, alu_op, busy, done, err, result_lo, result_hi
    );

    modport slave (
        input  start, op_div, opnd_a, opnd_b, host_a, host_b, host_op, alu_result,
        output alu_a, alu_b, alu_op, busy, done, err, result_lo, result_hi
    );
endinterface

`default_nettype wire

// File: rtl/alu_muldiv_seq.sv
//------------------------------------------------------------------------------
// Module : alu_muldiv_seq
// Brief  : Multi-cycle 10-bit multiply / unsigned divide on the shared ALU.
//          Optional MULDIV_EARLY_EXIT_EN ends a multiply once the multiplier is 0.
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module alu_muldiv_seq #(
    parameter int ITER = 10
) (
    input  wire logic         clk,
    input  wire logic         rst,
    alu_muldiv_seq_if.slave   bus
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_MUL     = 3'd1;
    localparam logic [2:0] S_DIV_CMP = 3'd2;
    localparam logic [2:0] S_DIV_SUB = 3'd3;
    localparam logic [2:0] S_FIN     = 3'd4;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_LT  = 2'b11;

    localparam logic [3:0] K_LAST = 4'(ITER - 1);

    logic [2:0] state_q, state_d;
    logic       op_div_q, op_div_d;
    logic [9:0] a_q, a_d;          // multiplicand / dividend shifter
    logic [9:0] b_q, b_d;          // multiplier / divisor
    logic [9:0] acc_q, acc_d;      // product / quotient
    logic [9:0] rem_q, rem_d;
    logic [3:0] k_q, k_d;
    logic       err_pend_q, err_pend_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic       err_q, err_d;
    logic [9:0] res_lo_q, res_lo_d;
    logic [9:0] res_hi_q, res_hi_d;

    logic [9:0] w_rem_shift;
    logic       w_k_last;
    logic       w_div_zero;
    logic       w_div_range;

    assign w_rem_shift = {rem_q[8:0], a_q[9]};
    assign w_k_last    = (k_q == K_LAST);
    assign w_div_zero  = (bus.opnd_b == 10'd0);
    assign w_div_range = bus.opnd_a[9] | (|bus.opnd_b[9:8]);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            op_div_q   <= 1'b0;
            a_q        <= '0;
            b_q        <= '0;
            acc_q      <= '0;
            rem_q      <= '0;
            k_q        <= '0;
            err_pend_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            res_lo_q   <= '0;
            res_hi_q   <= '0;
        end else begin
            state_q    <= state_d;
            op_div_q   <= op_div_d;
            a_q        <= a_d;
            b_q        <= b_d;
            acc_q      <= acc_d;
            rem_q      <= rem_d;
            k_q        <= k_d;
            err_pend_q <= err_pend_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            err_q      <= err_d;
            res_lo_q   <= res_lo_d;
            res_hi_q   <= res_hi_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    if (!bus.op_div) begin
`ifdef MULDIV_EARLY_EXIT_EN
                        state_d = w_div_zero ? S_FIN : S_MUL;
`else
                        state_d = S_MUL;
`endif
                    end else if (w_div_zero || w_div_range) begin
                        state_d = S_FIN;
                    end else begin
                        state_d = S_DIV_CMP;
                    end
                end
            end
            S_MUL: begin
                if (w_k_last) begin
                    state_d = S_FIN;
                end
`ifdef MULDIV_EARLY_EXIT_EN
                else if (b_q[9:1] == 9'd0) begin
                    state_d = S_FIN;
                end
`endif
            end
            // alu_result[0] is the "shifted rem < divisor" flag from the LT op
            S_DIV_CMP: begin
                if (!bus.alu_result[0]) begin
                    state_d = S_DIV_SUB;
                end else if (w_k_last) begin
                    state_d = S_FIN;
                end
            end
            S_DIV_SUB: state_d = w_k_last ? S_FIN : S_DIV_CMP;
            S_FIN:     state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    always_comb begin
        op_div_d   = op_div_q;
        a_d        = a_q;
        b_d        = b_q;
        acc_d      = acc_q;
        rem_d      = rem_q;
        k_d        = k_q;
        err_pend_d = err_pend_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        err_d      = err_q;
        res_lo_d   = res_lo_q;
        res_hi_d   = res_hi_q;
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    op_div_d   = bus.op_div;
                    a_d        = bus.opnd_a;
                    b_d        = bus.opnd_b;
                    k_d        = '0;
                    busy_d     = 1'b1;
                    acc_d      = '0;
                    rem_d      = '0;
                    err_pend_d = 1'b0;
                    if (bus.op_div && w_div_zero) begin
                        acc_d      = 10'h3FF;
                        rem_d      = bus.opnd_a;
                        err_pend_d = 1'b1;
                    end else if (bus.op_div && w_div_range) begin
                        err_pend_d = 1'b1;
                    end
                end
            end
            S_MUL: begin
                if (b_q[0]) begin
                    acc_d = bus.alu_result;
                end
                a_d = a_q << 1;
                b_d = b_q >> 1;
                k_d = k_q + 4'd1;
            end
            S_DIV_CMP: begin
                rem_d = w_rem_shift;
                a_d   = a_q << 1;
                if (bus.alu_result[0]) begin
                    acc_d = {acc_q[8:0], 1'b0};
                    k_d   = k_q + 4'd1;
                end
            end
            S_DIV_SUB: begin
                rem_d = bus.alu_result;
                acc_d = {acc_q[8:0], 1'b1};
                k_d   = k_q + 4'd1;
            end
            S_FIN: begin
                busy_d   = 1'b0;
                done_d   = 1'b1;
                err_d    = err_pend_q;
                res_lo_d = acc_q;
                res_hi_d = op_div_q ? rem_q : 10'd0;
            end
            default: ;
        endcase
    end

    // ALU drive depends only on registered state, never on alu_result
    always_comb begin
        bus.alu_a  = bus.host_a;
        bus.alu_b  = bus.host_b;
        bus.alu_op = bus.host_op;
        case (state_q)
            S_MUL: begin
                bus.alu_a  = acc_q;
                bus.alu_b  = a_q;
                bus.alu_op = OP_ADD;
            end
            S_DIV_CMP: begin
                bus.alu_a  = w_rem_shift;
                bus.alu_b  = b_q;
                bus.alu_op = OP_LT;
            end
            S_DIV_SUB: begin
                bus.alu_a  = rem_q;
                bus.alu_b  = b_q;
                bus.alu_op = OP_SUB;
            end
            default: ;
        endcase
    end

    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.err       = err_q;
    assign bus.result_lo = res_lo_q;
    assign bus.result_hi = res_hi_q;

endmodule

`default_nettype wire

// File: tb/tb_alu_muldiv_seq.sv
//------------------------------------------------------------------------------
// Module : tb_alu_muldiv_seq
// Brief  : Scoreboard bench for alu_muldiv_seq with a behavioural ALU model.
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_alu_muldiv_seq;

    logic clk;
    logic rst;
    int   cyc;
    int   n_vec;
    int   n_err;

    typedef struct {
        logic [9:0] lo;
        logic [9:0] hi;
        logic       err;
        int         lat;
        int         t0;
    } exp_t;

    exp_t sb[$];

    alu_muldiv_seq_if bus ();

    alu_muldiv_seq #(.ITER(10)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Shared ALU: add, sub, eq, lt (signed 11-bit compare of zero-extended operands)
    always_comb begin
        bus.alu_result = 10'd0;
        case (bus.alu_op)
            2'b00: bus.alu_result = bus.alu_a + bus.alu_b;
            2'b01: bus.alu_result = bus.alu_a - bus.alu_b;
            2'b10: bus.alu_result = {9'd0, bus.alu_a == bus.alu_b};
            2'b11: bus.alu_result = {9'd0, $signed({1'b0, bus.alu_a}) < $signed({1'b0, bus.alu_b})};
            default: ;
        endcase
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input int act, input int expv);
        n_vec++;
        if (act != expv) begin
            n_err++;
            $display("FAIL %s: got %0d, want %0d (cycle %0d)", nm, act, expv, cyc);
        end
    endtask

    function automatic exp_t model(input logic op, input logic [9:0] a, input logic [9:0] b);
        exp_t e;
        int   p;
        int   top;
        logic [9:0] q;
        e.t0 = 0;
        if (!op) begin
            p     = int'(a) * int'(b);
            e.lo  = p[9:0];
            e.hi  = 10'd0;
            e.err = 1'b0;
`ifdef MULDIV_EARLY_EXIT_EN
            top = -1;
            for (int i = 0; i < 10; i++) if (b[i]) top = i;
            e.lat = top + 2;
`else
            top   = 9;
            e.lat = top + 2;
`endif
        end else if (b == 10'd0) begin
            e.lo = 10'h3FF; e.hi = a; e.err = 1'b1; e.lat = 1;
        end else if (a > 10'd511 || b > 10'd255) begin
            e.lo = 10'd0; e.hi = 10'd0; e.err = 1'b1; e.lat = 1;
        end else begin
            q     = a / b;
            e.lo  = q;
            e.hi  = a % b;
            e.err = 1'b0;
            e.lat = 11 + $countones(q);
        end
        return e;
    endfunction

    always @(negedge clk) begin
        if (!rst && bus.done) begin
            if (sb.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_done: got done=1, want no done (cycle %0d)", cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("result_lo", int'(bus.result_lo), int'(e.lo));
                chk("result_hi", int'(bus.result_hi), int'(e.hi));
                chk("err",       int'(bus.err),       int'(e.err));
                chk("latency",   cyc - e.t0,          e.lat);
            end
        end
    end

    task automatic check_host(input logic [9:0] ha, input logic [9:0] hb, input logic [1:0] hop);
        @(negedge clk);
        bus.host_a  = ha;
        bus.host_b  = hb;
        bus.host_op = hop;
        #1;
        chk("pass_a",  int'(bus.alu_a),  int'(ha));
        chk("pass_b",  int'(bus.alu_b),  int'(hb));
        chk("pass_op", int'(bus.alu_op), int'(hop));
    endtask

    task automatic run_op(input logic op, input logic [9:0] a, input logic [9:0] b, input bit noise);
        exp_t e;
        int   i;
        check_host(10'($urandom), 10'($urandom), 2'($urandom));
        bus.start  = 1'b1;
        bus.op_div = op;
        bus.opnd_a = a;
        bus.opnd_b = b;
        e = model(op, a, b);
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        e.t0 = cyc;
        sb.push_back(e);
        i = 0;
        while (sb.size() != 0 && i < 60) begin
            @(posedge clk);
            #1;
            i++;
            if (noise && e.lat > 4 && i == 2) begin
                bus.start  = 1'b1;
                bus.op_div = 1'($urandom);
                bus.opnd_a = 10'($urandom);
                bus.opnd_b = 10'($urandom);
            end else begin
                bus.start = 1'b0;
            end
        end
        bus.start = 1'b0;
        if (sb.size() != 0) begin
            n_vec++;
            n_err++;
            $display("FAIL done_timeout: got no done after %0d cycles, want done", i);
            sb.delete();
        end
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        rst         = 1'b1;
        bus.start   = 1'b0;
        bus.op_div  = 1'b0;
        bus.opnd_a  = 10'd0;
        bus.opnd_b  = 10'd0;
        bus.host_a  = 10'd0;
        bus.host_b  = 10'd0;
        bus.host_op = 2'd0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst_busy", int'(bus.busy),      0);
        chk("rst_done", int'(bus.done),      0);
        chk("rst_err",  int'(bus.err),       0);
        chk("rst_lo",   int'(bus.result_lo), 0);
        chk("rst_hi",   int'(bus.result_hi), 0);

        check_host(10'd5, 10'd5, 2'b10);

        run_op(1'b0, 10'd13,   10'd11,  1'b1);
        run_op(1'b0, 10'h3FD,  10'd5,   1'b0);
        run_op(1'b0, 10'd40,   10'd40,  1'b1);
        run_op(1'b1, 10'd500,  10'd7,   1'b1);
        run_op(1'b1, 10'd255,  10'd255, 1'b0);
        run_op(1'b1, 10'd9,    10'd0,   1'b0);
        run_op(1'b1, 10'd600,  10'd3,   1'b0);
        run_op(1'b1, 10'd511,  10'd1,   1'b1);
        run_op(1'b1, 10'd0,    10'd255, 1'b0);
        run_op(1'b1, 10'd100,  10'd256, 1'b0);
        run_op(1'b0, 10'd100,  10'd1,   1'b0);
        run_op(1'b0, 10'd77,   10'd0,   1'b0);

        // Abort a multiply during iteration 5; no done may follow
        @(negedge clk);
        bus.start  = 1'b1;
        bus.op_div = 1'b0;
        bus.opnd_a = 10'd13;
        bus.opnd_b = 10'h3FF;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("abort_busy", int'(bus.busy),      0);
        chk("abort_done", int'(bus.done),      0);
        chk("abort_err",  int'(bus.err),       0);
        chk("abort_lo",   int'(bus.result_lo), 0);
        chk("abort_hi",   int'(bus.result_hi), 0);
        chk("abort_pass", int'(bus.alu_a),     int'(bus.host_a));
        repeat (15) @(posedge clk);
        run_op(1'b0, 10'd6, 10'd7, 1'b0);

        for (int n = 0; n < 150; n++) begin
            logic       op;
            logic [9:0] a;
            logic [9:0] b;
            int         sel;
            op  = 1'($urandom);
            sel = int'($urandom_range(0, 9));
            a   = 10'($urandom);
            b   = 10'($urandom);
            if (op && sel < 7) begin
                a = 10'($urandom_range(0, 511));
                b = 10'($urandom_range(1, 255));
            end else if (op && sel == 7) begin
                b = 10'd0;
            end else if (!op && sel < 3) begin
                b = 10'($urandom_range(0, 15));
            end
            run_op(op, a, b, bit'($urandom));
        end

        repeat (5) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
